// File: rtl/inv_mask_encoder_if.sv
// inv_mask_encoder_if
//   Valid/ready stream bundle for inv_mask_encoder. It carries both the
//   mask input stream (m_*) and the encoded output stream (d_*).
//
//   m_in    : inverse-mask word, driven by the mask producer
//   m_valid : m_in is valid this cycle
//   m_ready : encoder accepts m_in this cycle
//   d_out   : recovered shift amount
//   d_err   : the mask that produced d_out was illegal
//   d_valid : d_out / d_err are valid
//   d_ready : consumer accepts d_out this cycle
//
//   slave  : the encoder's view (consumes m_*, produces d_*)
//   master : the environment's view (produces m_*, consumes d_*)
interface inv_mask_encoder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
);
  logic [WIDTH-1:0] m_in;
  logic             m_valid;
  logic             m_ready;
  logic [AW-1:0]    d_out;
  logic             d_err;
  logic             d_valid;
  logic             d_ready;

  modport master (
    output m_in,
    output m_valid,
    input  m_ready,
    input  d_out,
    input  d_err,
    input  d_valid,
    output d_ready
  );

  modport slave (
    input  m_in,
    input  m_valid,
    output m_ready,
    output d_out,
    output d_err,
    output d_valid,
    input  d_ready
  );
endinterface

// File: rtl/inv_mask_encoder.sv
// inv_mask_encoder
//   Recovers a shift amount n from an inverse-mask word ({WIDTH{1'b1}} >> n)
//   and flags any word that is not such a mask (d_out = 0, d_err = 1).
//   Two-stage valid/ready pipeline:
//     S1 registers the raw mask, S2 registers the encoded result.
//   Full throughput with backpressure; a saturating counter tracks how many
//   illegal masks have been handed to the consumer.
//
//   Ports:
//     clk     : system clock, rising edge
//     rst_n   : asynchronous active-low reset
//     bus     : stream bundle (slave view), see inv_mask_encoder_if
//     err_clr : synchronous clear of err_cnt, wins over an increment
//     err_cnt : saturating count of illegal masks delivered
module inv_mask_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  inv_mask_encoder_if.slave   bus,
  input  logic                err_clr,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1: raw mask
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_mask;

  // Stage 2: encoded result
  logic             r_d_valid;
  logic [AW-1:0]    r_d_out;
  logic             r_d_err;

  logic [CNT_W-1:0] r_err_cnt;

  logic             w_s2_load;
  logic             w_m_ready;
  logic             w_out_hs;
  logic [AW-1:0]    w_enc_out;
  logic             w_enc_err;

  // S2 can take the S1 word when it is empty or being drained this cycle.
  assign w_s2_load = r_s1_valid && (!r_d_valid || bus.d_ready);
  // Depends only on state and d_ready, never on m_valid.
  assign w_m_ready = !r_s1_valid || w_s2_load;
  assign w_out_hs  = r_d_valid && bus.d_ready;

  // Legal masks are all distinct, so at most one comparison can hit.
  // Anything that hits none (all-zeros included) is reported as an error.
  always_comb begin
    w_enc_out = '0;
    w_enc_err = 1'b1;
    for (int unsigned n = 0; n < WIDTH; n++) begin
      if (r_s1_mask == (ONES >> n)) begin
        w_enc_out = AW'(n);
        w_enc_err = 1'b0;
      end
    end
  end

  // Stage 1. Whenever the slot is free (or being vacated) it follows m_valid,
  // so an idle input cycle leaves a bubble instead of re-sending the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mask  <= '0;
    end else if (w_m_ready) begin
      r_s1_valid <= bus.m_valid;
      if (bus.m_valid) begin
        r_s1_mask <= bus.m_in;
      end
    end
  end

  // Stage 2. d_out/d_err only change on a load, so they hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_valid <= 1'b0;
      r_d_out   <= '0;
      r_d_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_d_valid <= 1'b1;
      r_d_out   <= w_enc_out;
      r_d_err   <= w_enc_err;
    end else if (w_out_hs) begin
      r_d_valid <= 1'b0;
    end
  end

  // Counts errors at delivery, not at acceptance, so words lost to a reset
  // are never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_out_hs && r_d_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign bus.m_ready = w_m_ready;
  assign bus.d_valid = r_d_valid;
  assign bus.d_out   = r_d_out;
  assign bus.d_err   = r_d_err;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_inv_mask_encoder.sv
// tb_inv_mask_encoder
//   Scoreboard bench. Stimulus pushes the hand-computed expected result when
//   a word is accepted; a negedge monitor pops and compares on every output
//   handshake and tracks the expected error counters. A second encoder with
//   CNT_W=2 runs in lockstep on the same inputs to exercise saturation.
module tb_inv_mask_encoder;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  inv_mask_encoder_if #(.WIDTH(8), .AW(3)) bus ();
  inv_mask_encoder_if #(.WIDTH(8), .AW(3)) bus2 ();

  assign bus2.m_in    = bus.m_in;
  assign bus2.m_valid = bus.m_valid;
  assign bus2.d_ready = bus.d_ready;

  inv_mask_encoder #(.WIDTH(8), .AW(3), .CNT_W(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_clr (err_clr),
    .err_cnt (cnt8)
  );

  inv_mask_encoder #(.WIDTH(8), .AW(3), .CNT_W(2)) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus2),
    .err_clr (err_clr),
    .err_cnt (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] out;
    logic       err;
    time        acc_t;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   e8    = 0;
  int   e2    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: walk the legal mask down one bit at a time.
  function automatic logic [3:0] model(input logic [7:0] m);
    logic [7:0] legal;
    legal = 8'hFF;
    for (int n = 0; n < 8; n++) begin
      if (m == legal) return {1'b0, 3'(n)};
      legal = legal >> 1;
    end
    return 4'b1000;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  // acc_t records the edge that started the presenting cycle, so a word
  // presented after edge k shows on d_valid at edge k+2 (negedge k+2 = +25).
  task automatic send(input logic [7:0] m, input logic [2:0] eo, input logic ee, input bit lat);
    bit   rdy;
    exp_t e;
    bus.m_in    = m;
    bus.m_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = bus.m_ready;
      @(posedge clk);
      if (rdy) begin
        e.out   = eo;
        e.err   = ee;
        e.acc_t = $time - 10;
        e.lat   = lat;
        q.push_back(e);
        #1 bus.m_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: mask %0h never accepted", m);
    #1 bus.m_valid = 1'b0;
  endtask

  task automatic drain();
    bus.d_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.d_valid) break;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  logic p_stall = 1'b0;
  logic [2:0] p_out;
  logic p_err;

  always @(negedge clk) begin
    exp_t e;
    logic hs;
    logic herr;
    if (!rst_n) begin
      q.delete();
      e8      = 0;
      e2      = 0;
      p_stall = 1'b0;
    end else begin
      chk("err_cnt", cnt8, e8);
      chk("err_cnt_w2", cnt2, e2);
      if (p_stall) begin
        chk("stall_valid", bus.d_valid, 1);
        chk("stall_out", bus.d_out, p_out);
        chk("stall_err", bus.d_err, p_err);
      end
      hs   = bus.d_valid && bus.d_ready;
      herr = 1'b0;
      if (hs) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got d_out=%0d d_err=%0d with nothing pending",
                   bus.d_out, bus.d_err);
        end else begin
          e = q.pop_front();
          chk("d_out", bus.d_out, e.out);
          chk("d_err", bus.d_err, e.err);
          chk("w2_valid", bus2.d_valid, 1);
          chk("w2_out", bus2.d_out, e.out);
          chk("w2_err", bus2.d_err, e.err);
          if (e.lat) chk("latency", 32'($time - e.acc_t), 25);
          herr = e.err;
        end
      end
      if (err_clr) begin
        e8 = 0;
        e2 = 0;
      end else if (hs && herr) begin
        if (e8 < 255) e8++;
        if (e2 < 3) e2++;
      end
      p_stall = bus.d_valid && !bus.d_ready;
      p_out   = bus.d_out;
      p_err   = bus.d_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  logic [7:0] legal_t [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
  logic [7:0] bad_t   [4] = '{8'h00, 8'hF0, 8'h7B, 8'h80};
  bit         rnd_done;

  initial begin
    logic [7:0] w;
    logic [3:0] r;
    rst_n       = 1'b0;
    err_clr     = 1'b0;
    bus.m_in    = '0;
    bus.m_valid = 1'b0;
    bus.d_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_d_valid", bus.d_valid, 0);
    chk("rst_d_out", bus.d_out, 0);
    chk("rst_d_err", bus.d_err, 0);
    chk("rst_err_cnt", cnt8, 0);
    chk("rst_m_ready", bus.m_ready, 1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_m_ready", bus.m_ready, 1);
    chk("idle_d_valid", bus.d_valid, 0);

    // 1: legal sweep, back-to-back, fixed latency
    for (int i = 0; i < 8; i++) send(legal_t[i], 3'(i), 1'b0, 1'b1);
    drain();
    chk("sweep_err_cnt", cnt8, 0);

    // 2: illegal masks
    for (int i = 0; i < 4; i++) send(bad_t[i], 3'd0, 1'b1, 1'b0);
    drain();
    chk("illegal_err_cnt", cnt8, 4);

    // 3: backpressure, d_ready low for 5 edges
    bus.d_ready = 1'b0;
    send(8'hFF, 3'd0, 1'b0, 1'b0);
    send(8'h0F, 3'd4, 1'b0, 1'b0);
    chk("bp_m_ready_low", bus.m_ready, 0);
    fork
      begin
        send(8'h01, 3'd7, 1'b0, 1'b0);
        send(8'h3F, 3'd2, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.d_ready = 1'b1;
        #1 chk("bp_m_ready_rise", bus.m_ready, 1);
      end
    join
    drain();

    // 4: saturation of the 2-bit counter, then clear colliding with an error
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(bad_t[i % 4], 3'd0, 1'b1, 1'b0);
    drain();
    chk("sat_cnt_w2", cnt2, 3);
    chk("sat_cnt_w8", cnt8, 5);
    bus.d_ready = 1'b0;
    send(8'h00, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.d_valid) break;
    end
    chk("clr_setup_valid", bus.d_valid, 1);
    @(posedge clk);
    #1;
    err_clr     = 1'b1;
    bus.d_ready = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("clr_wins_w8", cnt8, 0);
    chk("clr_wins_w2", cnt2, 0);
    drain();

    // 5: asynchronous reset with both stages full
    send(8'h7B, 3'd0, 1'b1, 1'b0);
    drain();
    chk("pre_rst_cnt", cnt8, 1);
    bus.d_ready = 1'b0;
    send(8'h3F, 3'd2, 1'b0, 1'b0);
    send(8'h0F, 3'd4, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_d_valid", bus.d_valid, 0);
    chk("mid_rst_d_out", bus.d_out, 0);
    chk("mid_rst_d_err", bus.d_err, 0);
    chk("mid_rst_cnt", cnt8, 0);
    chk("mid_rst_m_ready", bus.m_ready, 1);
    @(posedge clk);
    #3;
    rst_n       = 1'b1;
    bus.d_ready = 1'b1;
    @(posedge clk);
    #1;
    send(8'h07, 3'd5, 1'b0, 1'b1);
    drain();

    // 6: random bubbles and random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
          if ($urandom_range(0, 1) == 1) w = 8'hFF >> $urandom_range(0, 7);
          else w = 8'($urandom);
          r = model(w);
          send(w, r[2:0], r[3], 1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.d_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    drain();
    chk("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
